// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: active-low 7-segment glyph table, blank pattern, capture FSM states and decoder.
package seven_segment_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {IDLE, SETTLE} state_e;
  // Returns {err, nibble}; nibble is 0 whenever err is set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++) if (seg == SEG_GLYPHS[i]) r = {1'b0, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/seven_segment_sync.sv
// seven_segment_sync: STAGES-deep 7-bit synchronizer, resets to the blank pattern.
module seven_segment_sync
  import seven_segment_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic [6:0] seg_o
);
  logic [STAGES-1:0][6:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {STAGES{SEG_BLANK}};
    else        sync_q <= {sync_q[STAGES-2:0], seg_i};
  assign seg_o = sync_q[STAGES-1];
endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: settles and decodes an active-low segment bus into a valid/ready nibble stream.
// Define SEVEN_SEGMENT_CAPTURE_ERRCNT_EN to add the saturating ERR_CNT output.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [6:0] SEG,
  input  logic       OUT_READY,
  output logic       OUT_VALID,
  output logic [3:0] OUT_NIBBLE,
  output logic       OUT_ERR,
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
  output logic       OVERRUN,
  output logic [7:0] ERR_CNT
`else
  output logic       OVERRUN
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  logic [6:0] s, cand_q, cand_d, last_q, last_d, emit_pat;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  state_e state_q, state_d;
  logic fire, emit, valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
  logic [3:0] nib_q, nib_d;
  logic [4:0] dec;
  seven_segment_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .seg_i (SEG),
    .seg_o (s)
  );
  // A "fresh" sample (IDLE, or a change during SETTLE) restarts the candidate at count 1.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    emit_pat = cand_q;
    fire     = 1'b0;
    cnt_inc  = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (state_q == IDLE || s != cand_q) begin
      emit_pat = s;
      if (s == last_q) state_d = IDLE;
      else if (CNT_MAX <= CW'(1)) begin
        fire    = 1'b1;
        state_d = IDLE;
      end else begin
        cand_d  = s;
        cnt_d   = CW'(1);
        state_d = SETTLE;
      end
    end else if (cnt_inc >= CNT_MAX) begin
      fire    = 1'b1;
      state_d = IDLE;
    end else cnt_d = cnt_inc;
    if (fire) last_d = emit_pat;
  end
  assign dec     = seg_decode(emit_pat);
  assign emit    = fire && emit_pat != SEG_BLANK;
  assign valid_d = emit || (valid_q && !OUT_READY);
  assign nib_d   = emit ? dec[3:0] : nib_q;
  assign err_d   = emit ? dec[4] : err_q;
  assign ovr_d   = ovr_q || (emit && valid_q && !OUT_READY);
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      cand_q  <= SEG_BLANK;
      cnt_q   <= '0;
      last_q  <= SEG_BLANK;
      valid_q <= 1'b0;
      nib_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      nib_q   <= nib_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  assign OUT_VALID  = valid_q;
  assign OUT_NIBBLE = nib_q;
  assign OUT_ERR    = err_q;
  assign OVERRUN    = ovr_q;
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  assign errcnt_d = (emit && dec[4] && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  assign ERR_CNT = errcnt_q;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed bench for seven_segment_capture with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_seven_segment_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic ready = 1'b1;
  logic valid, err, ovr;
  logic [3:0] nib;
  int checks = 0;
  int errors = 0;
  logic [4:0] words[$];
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  seven_segment_capture #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .SEG        (seg),
    .OUT_READY  (ready),
    .OUT_VALID  (valid),
    .OUT_NIBBLE (nib),
    .OUT_ERR    (err),
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    .OVERRUN    (ovr),
    .ERR_CNT    (err_cnt)
`else
    .OVERRUN    (ovr)
`endif
  );
  always #5 clk = ~clk;
  // Inputs only move just after a rising edge, so a negedge view sees the handshake of the next edge.
  always @(negedge clk) if (rst_n && valid && ready) words.push_back({err, nib});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #3;
    check("rst_valid", valid, 0);
    check("rst_nibble", nib, 0);
    check("rst_err", err, 0);
    check("rst_overrun", ovr, 0);
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    check("rst_errcnt", err_cnt, 0);
`endif
    step(2);
    rst_n = 1'b1;
    step(2);
    seg = 7'h12;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("t1_valid_c%0d", i), valid, i == 6);
      if (i == 6) check("t1_word", {err, nib}, 5'h05);
    end
    step(4);
    check("t1_count", words.size(), 1);
    words.delete();
    seg = 7'h7F;
    step(10);
    seg = 7'h12;
    step(2);
    seg = 7'h46;
    step(12);
    check("t2_count", words.size(), 1);
    check("t2_word", words[0], 5'h0C);
    words.delete();
    seg = 7'h00;
    step(10);
    check("t3_first", words.size(), 1);
    seg = 7'h7F;
    step(10);
    check("t3_blank", words.size(), 1);
    seg = 7'h00;
    step(10);
    check("t3_again", words.size(), 2);
    check("t3_word", words[1], 5'h08);
    words.delete();
    seg = 7'h55;
    step(10);
    check("t4_count", words.size(), 1);
    check("t4_word", words[0], 5'h10);
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    check("t4_errcnt", err_cnt, 1);
`endif
    words.delete();
    ready = 1'b0;
    seg = 7'h79;
    step(8);
    check("t5_valid1", valid, 1);
    check("t5_nib1", nib, 1);
    check("t5_ovr1", ovr, 0);
    seg = 7'h24;
    step(8);
    check("t5_valid2", valid, 1);
    check("t5_nib2", nib, 2);
    check("t5_ovr2", ovr, 1);
    ready = 1'b1;
    step();
    check("t5_drop", valid, 0);
    step(3);
    check("t5_count", words.size(), 1);
    check("t5_word", words[0], 5'h02);
    ready = 1'b0;
    seg = 7'h12;
    step(8);
    check("t6_pending", valid, 1);
    seg = 7'h40;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    words.delete();
    check("t6_valid", valid, 0);
    check("t6_nibble", nib, 0);
    check("t6_err", err, 0);
    check("t6_overrun", ovr, 0);
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    check("t6_errcnt", err_cnt, 0);
`endif
    seg = 7'h79;
    ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t6_count", words.size(), 1);
    check("t6_word", words[0], 5'h01);
    words.delete();
    for (int g = 0; g < 16; g++) begin
      seg = GLYPH[g];
      step(8);
    end
    check("t7_count", words.size(), 16);
    for (int g = 0; g < 16 && g < words.size(); g++)
      check($sformatf("t7_glyph%0d", g), words[g], g);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
